wb_regfile: RTL and testbench

Writeback stage and architectural register file for the five-stage MIPS pipeline, fed directly by the MEM/WB pipeline register. It selects the writeback value (ALU result, full load word, or sign-extended load byte), commits it to the 32×32 register file, and serves the two combinational read ports used by the ID stage. It also keeps a committed-write counter for performance and debug.

---
 rtl/pipeline_pkg.sv | 12 +
 rtl/load_align.sv | 26 ++
 rtl/wb_regfile.sv | 69 ++++++
 tb/tb_wb_regfile.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared writeback control encoding for the MIPS pipeline
package pipeline_pkg;

  localparam int WB_REG_WRITE  = 0;
  localparam int WB_MEM_TO_REG = 1;
  localparam int WB_LOAD_BYTE  = 2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef logic [2:0] wb_ctrl_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - big-endian byte select and sign-extend for byte loads
module load_align #(
  parameter int DATA_W = 32
) (
  input  logic [31:0]       word,
  input  logic [1:0]        offset,
  output logic [DATA_W-1:0] data
);

  logic [7:0] byte_sel;

  // Offset 0 addresses the most significant byte of the word.
  always_comb begin
    byte_sel = word[31:24];
    case (offset)
      2'b00: byte_sel = word[31:24];
      2'b01: byte_sel = word[23:16];
      2'b10: byte_sel = word[15:8];
      2'b11: byte_sel = word[7:0];
      default: byte_sel = word[31:24];
    endcase
  end

  assign data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback select, 32x32 register file and commit counter
// Optional same-cycle read bypass of the pending write: WB_BYPASS_EN
module wb_regfile
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        wb_ctrl_wb,
  input  logic [31:0]       dm_r_data_wb,
  input  logic [31:0]       alu_result_wb,
  input  logic [4:0]        reg_w_addr_wb,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [31:0]       rs_data,
  output logic [31:0]       rt_data,
  output logic [31:0]       wb_data,
  output logic [CNT_W-1:0]  wb_count
);

  wb_ctrl_t          ctrl;
  logic [31:0]       byte_data;
  logic              commit;
  logic [31:0]       regs [32];
  logic [31:0]       array_rs;
  logic [31:0]       array_rt;

  assign ctrl = wb_ctrl_wb;

  load_align #(.DATA_W(32)) u_load_align (
    .word   (dm_r_data_wb),
    .offset (alu_result_wb[1:0]),
    .data   (byte_data)
  );

  always_comb begin
    wb_data = alu_result_wb;
    if (ctrl[WB_MEM_TO_REG])
      wb_data = ctrl[WB_LOAD_BYTE] ? byte_data : dm_r_data_wb;
  end

  assign commit = ctrl[WB_REG_WRITE] && (reg_w_addr_wb != REG_ZERO);

  // Entry 0 is held at zero by reset and never written; reads also mask it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
      wb_count <= '0;
    end else if (commit) begin
      regs[reg_w_addr_wb] <= wb_data;
      wb_count            <= wb_count + CNT_W'(1);
    end
  end

  assign array_rs = (rs_addr == REG_ZERO) ? '0 : regs[rs_addr];
  assign array_rt = (rt_addr == REG_ZERO) ? '0 : regs[rt_addr];

`ifdef WB_BYPASS_EN
  assign rs_data = (commit && (rs_addr == reg_w_addr_wb)) ? wb_data : array_rs;
  assign rt_data = (commit && (rt_addr == reg_w_addr_wb)) ? wb_data : array_rt;
`else
  assign rs_data = array_rs;
  assign rt_data = array_rt;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed vector bench for wb_regfile
module tb_wb_regfile;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       wb_ctrl_wb;
  logic [31:0]      dm_r_data_wb;
  logic [31:0]      alu_result_wb;
  logic [4:0]       reg_w_addr_wb;
  logic [4:0]       rs_addr;
  logic [4:0]       rt_addr;
  logic [31:0]      rs_data;
  logic [31:0]      rt_data;
  logic [31:0]      wb_data;
  logic [CNT_W-1:0] wb_count;

  int errors = 0;
  int checks = 0;

  wb_regfile #(.DATA_W(32), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_ctrl_wb    (wb_ctrl_wb),
    .dm_r_data_wb  (dm_r_data_wb),
    .alu_result_wb (alu_result_wb),
    .reg_w_addr_wb (reg_w_addr_wb),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .wb_data       (wb_data),
    .wb_count      (wb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] dm;
    logic [31:0] alu;
    logic [4:0]  waddr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] exp_wb;
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] c, input logic [31:0] dm, input logic [31:0] alu,
                       input logic [4:0] wa, input logic [4:0] ra, input logic [4:0] rb);
    wb_ctrl_wb    = c;
    dm_r_data_wb  = dm;
    alu_result_wb = alu;
    reg_w_addr_wb = wa;
    rs_addr       = ra;
    rt_addr       = rb;
  endtask

  initial begin
    // ctrl bits: {load_byte, mem_to_reg, reg_write}
    vecs[0] = '{3'b001, 32'h0,        32'hDEADBEEF, 5'd5,  5'd5,  5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        4'd1};
    vecs[1] = '{3'b111, 32'h12F45678, 32'h00000001, 5'd7,  5'd7,  5'd5,  32'hFFFFFFF4, 32'hFFFFFFF4, 32'hDEADBEEF, 4'd2};
    vecs[2] = '{3'b111, 32'h12F45678, 32'h00000003, 5'd8,  5'd8,  5'd7,  32'h00000078, 32'h00000078, 32'hFFFFFFF4, 4'd3};
    vecs[3] = '{3'b011, 32'h12F45678, 32'h00000003, 5'd10, 5'd10, 5'd8,  32'h12F45678, 32'h12F45678, 32'h00000078, 4'd4};
    vecs[4] = '{3'b101, 32'h12F45678, 32'h00000002, 5'd11, 5'd11, 5'd10, 32'h00000002, 32'h00000002, 32'h12F45678, 4'd5};
    vecs[5] = '{3'b001, 32'h0,        32'hFFFFFFFF, 5'd0,  5'd0,  5'd0,  32'hFFFFFFFF, 32'h0,        32'h0,        4'd5};
    vecs[6] = '{3'b000, 32'h0,        32'h12345678, 5'd5,  5'd5,  5'd11, 32'h12345678, 32'hDEADBEEF, 32'h00000002, 4'd5};
    vecs[7] = '{3'b111, 32'h80FF0000, 32'h00000000, 5'd12, 5'd12, 5'd7,  32'hFFFFFF80, 32'hFFFFFF80, 32'hFFFFFFF4, 4'd6};
    vecs[8] = '{3'b111, 32'h00007F00, 32'h00000002, 5'd13, 5'd13, 5'd12, 32'h0000007F, 32'h0000007F, 32'hFFFFFF80, 4'd7};

    rst = 1'b1;
    drive(3'b000, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      #1;
      check($sformatf("reset_rs[%0d]", i), rs_data, 32'h0);
      check($sformatf("reset_rt[%0d]", 31 - i), rt_data, 32'h0);
    end
    check("reset_count", 32'(wb_count), 32'h0);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(vecs[i].ctrl, vecs[i].dm, vecs[i].alu, vecs[i].waddr, vecs[i].rs, vecs[i].rt);
      #1;
      check($sformatf("v%0d_wb_data", i), wb_data, vecs[i].exp_wb);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_rs", i), rs_data, vecs[i].exp_rs);
      check($sformatf("v%0d_rt", i), rt_data, vecs[i].exp_rt);
      check($sformatf("v%0d_count", i), 32'(wb_count), 32'(vecs[i].exp_cnt));
    end

    // Same-cycle write and read of r9 on both ports.
    @(negedge clk);
    drive(3'b001, 32'h0, 32'hA5A5A5A5, 5'd9, 5'd9, 5'd9);
    #1;
`ifdef WB_BYPASS_EN
    check("same_cycle_rs", rs_data, 32'hA5A5A5A5);
    check("same_cycle_rt", rt_data, 32'hA5A5A5A5);
`else
    check("same_cycle_rs", rs_data, 32'h0);
    check("same_cycle_rt", rt_data, 32'h0);
`endif
    @(posedge clk);
    #1;
    check("after_edge_rs", rs_data, 32'hA5A5A5A5);
    check("after_edge_rt", rt_data, 32'hA5A5A5A5);
    check("after_edge_count", 32'(wb_count), 32'd8);

    // Seven more commits bring the 4-bit counter to 15, one more wraps it.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(3'b001, 32'h0, 32'(100 + i), 5'd20, 5'd20, 5'd0);
    end
    @(posedge clk);
    #1;
    check("count_max", 32'(wb_count), 32'd15);
    check("r20_last", rs_data, 32'd106);
    @(negedge clk);
    drive(3'b001, 32'h0, 32'h0000BEEF, 5'd21, 5'd21, 5'd5);
    @(posedge clk);
    #1;
    check("count_wrap", 32'(wb_count), 32'd0);
    check("r21_written", rs_data, 32'h0000BEEF);

    // Reset between edges with a write pending; hold it across the edge.
    @(negedge clk);
    drive(3'b001, 32'h0, 32'h00000055, 5'd22, 5'd22, 5'd21);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_count", 32'(wb_count), 32'd0);
    check("midrst_r21", rt_data, 32'h0);
    @(posedge clk);
    #1;
    wb_ctrl_wb = 3'b000;
    #1;
    rst = 1'b0;
    #1;
    check("midrst_r22", rs_data, 32'h0);
    check("midrst_r21_after", rt_data, 32'h0);
    check("midrst_count_after", 32'(wb_count), 32'd0);
    rs_addr = 5'd5;
    rt_addr = 5'd9;
    #1;
    check("midrst_r5", rs_data, 32'h0);
    check("midrst_r9", rt_data, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
